// File: rtl/morra_cinese.sv
// Rock-paper-scissors match referee: scores one round per cycle and declares the match result.
// Optional MORRA_MANCHE_COUNT_EN adds a MANCHE_COUNT output mirroring the played-round counter.
module morra_cinese #(
  parameter int MIN_MANCHE = 4,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             INIZIO,
  input  logic [1:0]       PRIMO,
  input  logic [1:0]       SECONDO,
  output logic [1:0]       MANCHE,
`ifdef MORRA_MANCHE_COUNT_EN
  output logic [CNT_W-1:0] MANCHE_COUNT,
`endif
  output logic [1:0]       PARTITA
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] played_q, played_d;
  logic [CNT_W-1:0] win1_q, win1_d;
  logic [CNT_W-1:0] win2_q, win2_d;
  logic [1:0]       forb1_q, forb1_d;
  logic [1:0]       forb2_q, forb2_d;
  logic [1:0]       manche_q, manche_d;
  logic [1:0]       partita_q, partita_d;

  logic             p1_wins, p2_wins, round_bad;
  logic [CNT_W-1:0] played_n, win1_n, win2_n;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) ||
           (a == 2'b11 && b == 2'b10);
  endfunction

  // A forbidden slot of 00 never matches a valid move, so no separate enable is needed.
  assign p1_wins   = beats(PRIMO, SECONDO);
  assign p2_wins   = beats(SECONDO, PRIMO);
  assign round_bad = (PRIMO == 2'b00) || (SECONDO == 2'b00) ||
                     (PRIMO == forb1_q) || (SECONDO == forb2_q);

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    played_d  = played_q;
    win1_d    = win1_q;
    win2_d    = win2_q;
    forb1_d   = forb1_q;
    forb2_d   = forb2_q;
    manche_d  = 2'b00;
    partita_d = partita_q;
    played_n  = played_q + CNT_W'(1);
    win1_n    = win1_q + (p1_wins ? CNT_W'(1) : CNT_W'(0));
    win2_n    = win2_q + (p2_wins ? CNT_W'(1) : CNT_W'(0));

    if (INIZIO) begin
      max_d     = CNT_W'({PRIMO, SECONDO}) + CNT_W'(MIN_MANCHE);
      played_d  = '0;
      win1_d    = '0;
      win2_d    = '0;
      forb1_d   = 2'b00;
      forb2_d   = 2'b00;
      partita_d = 2'b00;
      state_d   = PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          if (!round_bad) begin
            played_d = played_n;
            win1_d   = win1_n;
            win2_d   = win2_n;
            // Only the most recent decisive winner carries a restriction.
            if (p1_wins) begin
              manche_d = 2'b01;
              forb1_d  = PRIMO;
              forb2_d  = 2'b00;
            end else if (p2_wins) begin
              manche_d = 2'b10;
              forb1_d  = 2'b00;
              forb2_d  = SECONDO;
            end else begin
              manche_d = 2'b11;
              forb1_d  = 2'b00;
              forb2_d  = 2'b00;
            end
            if (played_n >= CNT_W'(MIN_MANCHE) && win1_n >= win2_n + CNT_W'(2)) begin
              partita_d = 2'b01;
              state_d   = OVER;
            end else if (played_n >= CNT_W'(MIN_MANCHE) && win2_n >= win1_n + CNT_W'(2)) begin
              partita_d = 2'b10;
              state_d   = OVER;
            end else if (played_n == max_q) begin
              partita_d = (win1_n > win2_n) ? 2'b01 : (win2_n > win1_n) ? 2'b10 : 2'b11;
              state_d   = OVER;
            end
          end
        end
        OVER:    state_d = OVER;
        default: partita_d = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      max_q     <= CNT_W'(MIN_MANCHE);
      played_q  <= '0;
      win1_q    <= '0;
      win2_q    <= '0;
      forb1_q   <= 2'b00;
      forb2_q   <= 2'b00;
      manche_q  <= 2'b00;
      partita_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      played_q  <= played_d;
      win1_q    <= win1_d;
      win2_q    <= win2_d;
      forb1_q   <= forb1_d;
      forb2_q   <= forb2_d;
      manche_q  <= manche_d;
      partita_q <= partita_d;
    end
  end

  assign MANCHE  = manche_q;
  assign PARTITA = partita_q;
`ifdef MORRA_MANCHE_COUNT_EN
  assign MANCHE_COUNT = played_q;
`endif

endmodule

// File: tb/tb_morra_cinese.sv
// Self-checking bench for morra_cinese: vector table plus a 19-round max-length match.
module tb_morra_cinese;

  logic       clk;
  logic       rst;
  logic       inizio;
  logic [1:0] primo, secondo;
  logic [1:0] manche, partita;
`ifdef MORRA_MANCHE_COUNT_EN
  logic [4:0] manche_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic       r;
    logic       ini;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] em;
    logic [1:0] ep;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs[NV];

  morra_cinese dut (
    .clk(clk),
    .rst(rst),
    .INIZIO(inizio),
    .PRIMO(primo),
    .SECONDO(secondo),
    .MANCHE(manche),
`ifdef MORRA_MANCHE_COUNT_EN
    .MANCHE_COUNT(manche_count),
`endif
    .PARTITA(partita)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic ini, input logic [1:0] p1,
                      input logic [1:0] p2, input logic [1:0] em, input logic [1:0] ep,
                      input string name);
    logic [3:0] want;
    @(negedge clk);
    rst     = r;
    inizio  = ini;
    primo   = p1;
    secondo = p2;
    exp_q.push_back({em, ep});
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    checks++;
    if ({manche, partita} !== want) begin
      errors++;
      $display("FAIL %s: manche/partita=%b/%b required %b/%b",
               name, manche, partita, want[3:2], want[1:0]);
    end
  endtask

  initial begin
    rst = 1'b1; inizio = 1'b0; primo = 2'b00; secondo = 2'b00;
    // {rst, inizio, p1, p2, manche, partita}
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[2]  = '{1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00};
    vecs[3]  = '{1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
    vecs[4]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[5]  = '{1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00};
    vecs[6]  = '{1'b0, 1'b0, 2'b10, 2'b11, 2'b00, 2'b00};
    vecs[7]  = '{1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00};
    vecs[8]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[9]  = '{1'b0, 1'b0, 2'b01, 2'b11, 2'b01, 2'b00};
    vecs[10] = '{1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00};
    vecs[11] = '{1'b0, 1'b0, 2'b11, 2'b10, 2'b01, 2'b00};
    vecs[12] = '{1'b0, 1'b0, 2'b01, 2'b11, 2'b01, 2'b01};
    vecs[13] = '{1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b01};
    vecs[14] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b01};
    vecs[15] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[16] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b11, 2'b00};
    vecs[17] = '{1'b0, 1'b0, 2'b10, 2'b10, 2'b11, 2'b00};
    vecs[18] = '{1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00};
    vecs[19] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b11, 2'b11};
    vecs[20] = '{1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b11};
    vecs[21] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[22] = '{1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00};
    vecs[23] = '{1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00};
    vecs[24] = '{1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00};
    vecs[25] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b11, 2'b00};
    vecs[26] = '{1'b0, 1'b0, 2'b10, 2'b10, 2'b11, 2'b00};
    vecs[27] = '{1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00};
    vecs[28] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[29] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b11, 2'b01};
    vecs[30] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[31] = '{1'b0, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00};
    vecs[32] = '{1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
    vecs[33] = '{1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00};
    vecs[34] = '{1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00};
    vecs[35] = '{1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b10};
    vecs[36] = '{1'b1, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
    vecs[37] = '{1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].r, vecs[i].ini, vecs[i].p1, vecs[i].p2, vecs[i].em, vecs[i].ep,
           $sformatf("vec%0d", i));
    end

    // Max 19: alternating wins never open a 2-point gap; a draw on round 19 ends 9-9.
    step(1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, "cfg19");
    for (int i = 0; i < 18; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b0, 2'b01, 2'b11, 2'b01, 2'b00, $sformatf("alt%0d", i));
      else            step(1'b0, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00, $sformatf("alt%0d", i));
`ifdef MORRA_MANCHE_COUNT_EN
      checks++;
      if (manche_count !== 5'(i + 1)) begin
        errors++;
        $display("FAIL count%0d: manche_count=%0d required %0d", i, manche_count, i + 1);
      end
`endif
    end
    step(1'b0, 1'b0, 2'b10, 2'b10, 2'b11, 2'b11, "round19");
    step(1'b0, 1'b0, 2'b01, 2'b11, 2'b00, 2'b11, "hold19");
`ifdef MORRA_MANCHE_COUNT_EN
    checks++;
    if (manche_count !== 5'd19) begin
      errors++;
      $display("FAIL count_over: manche_count=%0d required 19", manche_count);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
